mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
Two-master arbiter that shares one single-port synchronous memory between the SoC's instruction-fetch port (m0) and data port (m1). It sits between the core's imem/dmem interfaces and the firmware/array RAM. The block grants requests round-robin, tracks the single in-flight access, and steers read data and the response strobe back to the owning master.

Parameters:
AW, 32, address width
DW, 32, data width (multiple of 8)
MEM_LAT, 1, memory read latency in cycles from mem_en to mem_rdata valid; legal range 1..4

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
m0_req  input  1  m0 request; held with m0_addr, m0_we, m0_wdata and m0_be stable until m0_gnt
m0_we  input  1  m0 write enable
m0_addr  input  AW  m0 byte address
m0_wdata  input  DW  m0 write data
m0_be  input  DW/8  m0 byte enables
m0_gnt  output  1  m0 request accepted this cycle
m0_rvalid  output  1  m0 response strobe (reads and writes)
m0_rdata  output  DW  m0 read data, valid with m0_rvalid on reads
m1_*  (same set as m0_*)  second master, identical semantics
mem_en  output  1  memory access strobe
mem_we  output  1  memory write
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_be  output  DW/8  memory byte enables
mem_rdata  input  DW  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- State: busy (1b), cnt (3b), owner (1b), owner_we (1b), prio (1b; 0 means m0 wins a tie). Reset clears all to 0.
- can_issue = !busy || (cnt == 1).
- Grant (combinational): if can_issue and exactly one request is present, grant it. If both request, grant m(prio). Only one gnt is high per cycle.
- Grant outputs: mem_en = m0_gnt | m1_gnt. mem_we, mem_addr, mem_wdata and mem_be mux from the granted master. When there is no grant, mem_en = 0 and all other mem_* outputs = 0.
- On a grant at edge t:
  - busy <= 1, cnt <= MEM_LAT, owner <= granted index, owner_we <= granted we.
  - prio <= the index that was not granted.
- No grant while busy: cnt decrements. When cnt == 1 and no new grant, busy <= 0 at the next edge.
- Response: mX_rvalid = busy && cnt == 1 && owner == X, combinational from registers. A grant at cycle t gives rvalid at cycle t+MEM_LAT.
- Read data: mX_rdata = mem_rdata when mX_rvalid && !owner_we, else 0.
- Back-to-back: a new grant may occur in the same cycle as the previous rvalid. With MEM_LAT=1, throughput is one access per cycle.
- Write completion: writes return an rvalid pulse with rdata = 0.
- Request withdrawal: a master may drop req before gnt with no side effect. After gnt, req may be held for the next access or dropped.
- Reset values: gnt, rvalid, rdata and mem_* are all 0 while rst is high.
- Reset mid-transaction: the in-flight access is discarded and no rvalid is produced. The first grant after reset deassertion is the earliest cycle any output is driven.
- Starvation bound: with both masters requesting continuously, each is granted at least every second grant.

Test Plan:
- Single read, MEM_LAT=1: m0 reads addr 0x10, memory holds 0xDEADBEEF -> m0_gnt and mem_en at cycle t; m0_rvalid=1 and m0_rdata=0xDEADBEEF at t+1; m1 outputs stay 0.
- Contention: m0 and m1 request every cycle from reset -> grants alternate m0, m1, m0, m1; each rvalid follows its grant by MEM_LAT and goes to the correct owner.
- MEM_LAT=3, m1 continuous reads -> grants at cycles 0, 3, 6; rvalid at 3, 6, 9; mem_en never asserted while cnt > 1.
- Write: m1 writes 0x12345678, be=4'b0011 -> mem_we=1 and mem_be=4'b0011 with the grant; m1_rvalid after MEM_LAT; m1_rdata=0.
- Withdrawal: m0_req pulses high for 1 cycle while the arbiter is busy with m1 (MEM_LAT=2) -> no m0_gnt and no m0_rvalid; prio unchanged.
- Reset mid-read: assert rst 1 cycle after m0's grant (MEM_LAT=3) -> all outputs 0 immediately; no m0_rvalid after deassertion; next tie grants m0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one single-port synchronous memory between two masters
//   (m0 = instruction fetch, m1 = data).
//   - Grants requests round-robin.
//   - Tracks the one access in flight.
//   - Returns the response strobe and read data to the master that owns
//     that access.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   mX_req/we/addr/      master X request. Held stable until mX_gnt.
//     wdata/be
//   mX_gnt               master X request accepted this cycle
//   mX_rvalid            response strobe for master X (reads and writes)
//   mX_rdata             read data; zero for writes and when idle
//   mem_en/we/addr/      memory access, driven only in the grant cycle
//     wdata/be
//   mem_rdata            memory read data, valid MEM_LAT cycles after mem_en
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_be,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_be,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata
);

  logic       busy_q, busy_d;
  logic [2:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       owner_we_q, owner_we_d;
  logic       prio_q, prio_d;

  logic can_issue;
  logic gnt0, gnt1;

  // A new access may start in the cycle where the previous one responds.
  // This is what allows one access per cycle when MEM_LAT=1.
  assign can_issue = !busy_q || (cnt_q == 3'd1);

  // When both masters request, prio_q picks the winner (0 means m0).
  // Grants are forced low while rst is high, so no grant can happen in reset.
  assign gnt0 = !rst && can_issue && m0_req && (!m1_req || !prio_q);
  assign gnt1 = !rst && can_issue && m1_req && (!m0_req ||  prio_q);

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;
  assign mem_en = gnt0 | gnt1;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (gnt0) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_be    = m0_be;
    end else if (gnt1) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_be    = m1_be;
    end
  end

  always_comb begin
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    owner_we_d = owner_we_q;
    prio_d     = prio_q;
    if (gnt0 || gnt1) begin
      busy_d     = 1'b1;
      cnt_d      = 3'(MEM_LAT);
      owner_d    = gnt1;
      owner_we_d = gnt1 ? m1_we : m0_we;
      prio_d     = gnt0;  // the master that lost gets priority next time
    end else if (busy_q) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= 1'b0;
      cnt_q      <= 3'd0;
      owner_q    <= 1'b0;
      owner_we_q <= 1'b0;
      prio_q     <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      owner_we_q <= owner_we_d;
      prio_q     <= prio_d;
    end
  end

  // The response fires in the last cycle of the in-flight access.
  assign m0_rvalid = busy_q && (cnt_q == 3'd1) && !owner_q;
  assign m1_rvalid = busy_q && (cnt_q == 3'd1) &&  owner_q;
  assign m0_rdata  = (m0_rvalid && !owner_we_q) ? mem_rdata : '0;
  assign m1_rdata  = (m1_rvalid && !owner_we_q) ? mem_rdata : '0;

endmodule
